// File: rtl/prefix_add_arbiter.sv
// prefix_add_arbiter
// Shares one combinational WIDTH-bit prefix adder between two requesters.
// A round-robin arbiter picks one valid/ready request per cycle into an issue
// stage (S1) that drives the adder. The adder result is captured into a
// result stage (S2) with valid/ready backpressure and tagged with the id.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_reqN_valid/o_reqN_ready   requester N handshake (N = 0, 1)
//   i_reqN_a/_b/_cin            requester N operands and carry-in
//   o_add_a/_b/_cin             operands to the external adder core
//   i_add_sum/_cout             adder core result (combinational)
//   o_res_valid/i_res_ready     result handshake
//   o_res_sum/_cout/_id         registered result and owning requester
//   o_cnt0/o_cnt1               accepted-transaction counters (wrapping)
module prefix_add_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req0_cin,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic             i_req1_cin,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b,
  output logic             o_add_cin,
  input  logic [WIDTH-1:0] i_add_sum,
  input  logic             i_add_cout,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_sum,
  output logic             o_res_cout,
  output logic             o_res_id,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1
);

  typedef struct packed {
    logic             id;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } issue_t;

  // Issue stage
  logic             r_s1_valid;
  issue_t           r_s1;

  // Result stage
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_cout;
  logic             r_res_id;

  // Arbitration and counters
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  issue_t           w_win;

  // Pipeline advance conditions; S1 may refill in the same edge S2 drains it.
  assign w_s2_load = !r_res_valid | i_res_ready;
  assign w_s1_load = !r_s1_valid | w_s2_load;

  // Round-robin: a lone valid wins; on a tie the side not granted last wins.
  // Readies are forced low while reset is asserted.
  assign w_grant0 = !rst & w_s1_load & i_req0_valid & (!i_req1_valid | r_last_grant);
  assign w_grant1 = !rst & w_s1_load & i_req1_valid & (!i_req0_valid | !r_last_grant);
  assign w_accept = w_grant0 | w_grant1;

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  // Winning operand mux
  always_comb begin
    w_win = '0;
    if (w_grant1) begin
      w_win.id  = 1'b1;
      w_win.cin = i_req1_cin;
      w_win.a   = i_req1_a;
      w_win.b   = i_req1_b;
    end else begin
      w_win.id  = 1'b0;
      w_win.cin = i_req0_cin;
      w_win.a   = i_req0_a;
      w_win.b   = i_req0_b;
    end
  end

  // Issue stage: operands only change on accept, so the adder inputs hold
  // their last value while S1 is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1         <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_accept) begin
        r_s1_valid   <= 1'b1;
        r_s1         <= w_win;
        r_last_grant <= w_grant1;
      end else if (w_s1_load) begin
        r_s1_valid   <= 1'b0;
      end
    end
  end

  // Result stage: captures the adder output for the issued operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_id    <= 1'b0;
    end else if (w_s2_load) begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res_sum  <= i_add_sum;
        r_res_cout <= i_add_cout;
        r_res_id   <= r_s1.id;
      end
    end
  end

  // Per-requester accept counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_grant0) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_grant1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign o_add_a     = r_s1.a;
  assign o_add_b     = r_s1.b;
  assign o_add_cin   = r_s1.cin;
  assign o_res_valid = r_res_valid;
  assign o_res_sum   = r_res_sum;
  assign o_res_cout  = r_res_cout;
  assign o_res_id    = r_res_id;
  assign o_cnt0      = r_cnt0;
  assign o_cnt1      = r_cnt1;

endmodule

// File: doc/prefix_add_arbiter.md
# prefix_add_arbiter

Sequencer that shares a single WIDTH-bit parallel-prefix adder (Knowles core) between two requesters. It performs round-robin arbitration over two valid/ready operand ports and registers the winning operands into an issue stage that drives the adder. It captures the adder result into an output stage with backpressure and returns it tagged with the requester id. It sits between the ALU-side clients and the adder datapath, which it drives through explicit adder ports so the core stays purely combinational.

## Interface
- WIDTH, 16, operand/sum width; must match the adder core
- CNT_W, 16, width of per-requester accepted-transaction counters

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 operands valid
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- add_a, add_b  out  WIDTH  operands to adder core, driven from issue register
- add_cin  out  1  carry-in to adder core
- add_sum  in  WIDTH  adder core sum, combinational from add_*
- add_cout  in  1  adder core carry-out
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result when valid&ready
- res_sum  out  WIDTH  registered sum
- res_cout  out  1  registered carry-out
- res_id  out  1  requester id (0/1) of this result
- cnt0, cnt1  out  CNT_W  transactions accepted from requester 0/1, wrap modulo 2^CNT_W

## Operation
- Two-stage pipeline: S1 (issue: valid bit, a, b, cin, id) drives add_*; S2 (result: res_valid, sum, cout, id) samples add_sum/add_cout.
- s2_load = !res_valid | res_ready; s1_load = !s1_valid | s2_load.
- S2 loads S1 contents plus adder output when s1_valid & s2_load. When s2_load and !s1_valid, res_valid clears.
- Arbiter: last_grant bit. Only one valid: that requester wins. Both valid: winner is !last_grant. last_grant updates to the winner only on an accept.
- reqX_ready = s1_load & (winner == X). reqX_ready may depend combinationally on both req valids and res_ready. Ready of a non-valid requester is 0.
- On accept: S1 loads the winner's a, b, cin, id. cntX increments, wrapping from 2^CNT_W-1 to 0.
- Loser's operands are ignored and must be held by the requester (standard valid/ready: valid may not drop until ready).
- Fairness: a continuously valid requester is accepted within 2 accepts.
- add_a/add_b/add_cin hold S1 contents even when s1_valid=0. The adder output is then don't-care and never captured.
- No reordering: results emerge in accept order.

## Timing
- Reset values: s1_valid=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, S1 operands=0, last_grant=1 (requester 0 wins first tie), cnt0=cnt1=0, both ready=0 during rst.
- Latency: accept at edge t → res_valid=1 after edge t+1 (visible in cycle t+1 to t+2 window), i.e. 2 register stages.
- Throughput: 1 accept/cycle while res_ready=1.
- Stall: with res_ready=0 and res_valid=1, S2 holds; S1 holds if valid. Readies drop when both stages are full; at most 2 in flight.
- Simultaneous res_ready and accept with full pipeline: S2 takes S1, S1 takes the new request in the same edge; no bubble.
- Reset mid-operation: in-flight S1/S2 contents are discarded, no result is emitted, and counters clear.

## Test plan
- Single request: req0 a=0x00FF, b=0x0001, cin=0, res_ready=1 → two edges later res_valid=1, res_sum=0x0100, res_cout=0, res_id=0, cnt0=1.
- Carry-out: req1 a=0xFFFF, b=0x0000, cin=1 → res_sum=0x0000, res_cout=1, res_id=1.
- Both requesters valid continuously for 6 cycles after reset → accept order 0,1,0,1,0,1; cnt0=3, cnt1=3; results in the same order.
- Backpressure: fill pipeline, hold res_ready=0 for 5 cycles → res_valid/res_sum stable, both readies 0, no loss. Release → 2 results back-to-back, then ready resumes.
- Counter wrap with CNT_W=4: 17 req0 accepts → cnt0=1.
- Assert rst with 2 transactions in flight → next cycle res_valid=0, cnt0=cnt1=0, no stale result after rst drops; first tie goes to requester 0.
